mem_bus_arbiter: RTL and testbench

Two-port arbiter and sequencer for the CPU's single 8-bit memory bus. It shares the bus between the fetch stage (port F, read-only) and the execute stage (port E, read/write). Each bus transaction runs through a registered IDLE/BUSY/DONE sequence with a per-transaction timeout. It replaces ad-hoc request muxing in the core top level, which keeps only the tristate driver for the shared data bus.

---
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch/execute) arbiter and IDLE/BUSY/DONE sequencer for the shared memory bus.
// Every bus value is latched at grant time; each transaction ends with a timeout or with mem_ready.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter bit RR_EN   = 1'b1,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              e_req,
  input  logic              e_we,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_ready,
  output logic [DATA_W-1:0] e_rdata,
  output logic              e_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic              last_e, last_e_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [1:0]        grant_nxt;
  logic              f_ready_nxt, f_err_nxt, e_ready_nxt, e_err_nxt;
  logic [DATA_W-1:0] f_rdata_nxt, e_rdata_nxt;
  logic              pick_e, tmo, finish;
  logic [DATA_W-1:0] cap_data;

  always_comb begin
    state_nxt     = state;
    last_e_nxt    = last_e;
    cnt_nxt       = cnt;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    grant_nxt     = grant;
    f_ready_nxt   = 1'b0;
    f_err_nxt     = 1'b0;
    e_ready_nxt   = 1'b0;
    e_err_nxt     = 1'b0;
    f_rdata_nxt   = f_rdata;
    e_rdata_nxt   = e_rdata;
    // On contention E wins unless round-robin says F is due (E was served last).
    pick_e   = e_req && (!f_req || !RR_EN || !last_e);
    // A mem_ready arriving in the timeout cycle still counts as a normal completion.
    tmo      = (TIMEOUT != 0) && (cnt == CNT_LAST) && !mem_ready;
    finish   = mem_ready || tmo;
    cap_data = mem_ready ? mem_rdata : '0;

    case (state)
      IDLE: begin
        if (f_req || e_req) begin
          mem_addr_nxt  = pick_e ? e_addr : f_addr;
          mem_we_nxt    = pick_e && e_we;
          mem_wdata_nxt = pick_e ? e_wdata : '0;
          mem_req_nxt   = 1'b1;
          grant_nxt     = pick_e ? 2'b10 : 2'b01;
          last_e_nxt    = pick_e;
          cnt_nxt       = '0;
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
        if (finish) begin
          if (grant[1]) begin
            e_rdata_nxt = cap_data;
            e_ready_nxt = 1'b1;
            e_err_nxt   = tmo;
          end else begin
            f_rdata_nxt = cap_data;
            f_ready_nxt = 1'b1;
            f_err_nxt   = tmo;
          end
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        grant_nxt = 2'b00;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_e    <= 1'b1;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant     <= 2'b00;
      f_ready   <= 1'b0;
      f_err     <= 1'b0;
      f_rdata   <= '0;
      e_ready   <= 1'b0;
      e_err     <= 1'b0;
      e_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      last_e    <= last_e_nxt;
      cnt       <= cnt_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      grant     <= grant_nxt;
      f_ready   <= f_ready_nxt;
      f_err     <= f_err_nxt;
      f_rdata   <= f_rdata_nxt;
      e_ready   <= e_ready_nxt;
      e_err     <= e_err_nxt;
      e_rdata   <= e_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin instance (dut 0) and a fixed-priority instance (dut 1)
// driven side by side, checked each cycle against a transaction-level model plus literal expectations.
module tb_mem_bus_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  logic          f_req[2], e_req[2], e_we[2], mem_ready[2];
  logic [AW-1:0] f_addr[2], e_addr[2], mem_addr[2];
  logic [DW-1:0] e_wdata[2], mem_rdata[2], f_rdata[2], e_rdata[2], mem_wdata[2];
  logic          f_ready[2], f_err[2], e_ready[2], e_err[2], mem_req[2], mem_we[2];
  logic [1:0]    grant[2];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1), .TIMEOUT(TMO)) dut_rr (
    .clk(clk), .rst(rst),
    .f_req(f_req[0]), .f_addr(f_addr[0]), .f_ready(f_ready[0]), .f_rdata(f_rdata[0]), .f_err(f_err[0]),
    .e_req(e_req[0]), .e_we(e_we[0]), .e_addr(e_addr[0]), .e_wdata(e_wdata[0]),
    .e_ready(e_ready[0]), .e_rdata(e_rdata[0]), .e_err(e_err[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]), .grant(grant[0]));

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0), .TIMEOUT(TMO)) dut_fp (
    .clk(clk), .rst(rst),
    .f_req(f_req[1]), .f_addr(f_addr[1]), .f_ready(f_ready[1]), .f_rdata(f_rdata[1]), .f_err(f_err[1]),
    .e_req(e_req[1]), .e_we(e_we[1]), .e_addr(e_addr[1]), .e_wdata(e_wdata[1]),
    .e_ready(e_ready[1]), .e_rdata(e_rdata[1]), .e_err(e_err[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]), .grant(grant[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Transaction-level model: owner 0=none 1=F 2=E, elapsed BUSY cycles, turnaround flag.
  int         m_owner[2], m_elapsed[2];
  bit         m_done[2], m_last_e[2];
  bit         e_wins, timed_out;
  logic       x_mem_req[2], x_mem_we[2], x_f_ready[2], x_f_err[2], x_e_ready[2], x_e_err[2];
  logic [7:0] x_addr[2], x_wdata[2], x_f_rdata[2], x_e_rdata[2];

  function automatic logic [1:0] owner_grant(input int o);
    return (o == 1) ? 2'b01 : (o == 2) ? 2'b10 : 2'b00;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_owner[d] = 0; m_elapsed[d] = 0; m_done[d] = 1'b0; m_last_e[d] = 1'b1;
        x_mem_req[d] = 0; x_mem_we[d] = 0; x_f_ready[d] = 0; x_f_err[d] = 0;
        x_e_ready[d] = 0; x_e_err[d] = 0; x_addr[d] = 0; x_wdata[d] = 0;
        x_f_rdata[d] = 0; x_e_rdata[d] = 0;
      end else begin
        x_f_ready[d] = 0; x_f_err[d] = 0; x_e_ready[d] = 0; x_e_err[d] = 0;
        if (m_owner[d] == 0) begin
          if (f_req[d] || e_req[d]) begin
            e_wins = e_req[d] && !(f_req[d] && d == 0 && m_last_e[d]);
            m_owner[d]   = e_wins ? 2 : 1;
            m_last_e[d]  = e_wins;
            m_elapsed[d] = 0;
            x_mem_req[d] = 1'b1;
            x_mem_we[d]  = e_wins && e_we[d];
            x_addr[d]    = e_wins ? e_addr[d] : f_addr[d];
            if (e_wins) x_wdata[d] = e_wdata[d];
          end
        end else if (m_done[d]) begin
          m_owner[d] = 0;
          m_done[d]  = 1'b0;
        end else begin
          m_elapsed[d]++;
          if (mem_ready[d] || (TMO > 0 && m_elapsed[d] == TMO)) begin
            timed_out = !mem_ready[d];
            x_mem_req[d] = 1'b0;
            x_mem_we[d]  = 1'b0;
            m_done[d]    = 1'b1;
            if (m_owner[d] == 1) begin
              x_f_ready[d] = 1'b1; x_f_err[d] = timed_out;
              x_f_rdata[d] = timed_out ? 8'h00 : mem_rdata[d];
            end else begin
              x_e_ready[d] = 1'b1; x_e_err[d] = timed_out;
              x_e_rdata[d] = timed_out ? 8'h00 : mem_rdata[d];
            end
          end
        end
      end
    end
  end

  typedef struct {
    bit         is_e;
    bit         err;
    logic [7:0] rdata;
    int         busy;
    logic [7:0] addr;
    bit         we;
    logic [7:0] wdata;
  } txn_t;

  txn_t       log0[$], log1[$];
  txn_t       rec;
  int         busy_n[2], lat[2];
  bit         ready_always[2], f_again[2], e_again[2], f_gap[2], e_gap[2], cur_we[2];
  logic [7:0] rdata_val[2], cur_addr[2], cur_wdata[2];

  // Per-cycle compare, transaction log, requester behaviour and memory responder.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("mem_req", d, 32'(mem_req[d]), 32'(x_mem_req[d]));
      chk("mem_we", d, 32'(mem_we[d]), 32'(x_mem_we[d]));
      chk("grant", d, 32'(grant[d]), 32'(owner_grant(m_owner[d])));
      chk("f_ready", d, 32'(f_ready[d]), 32'(x_f_ready[d]));
      chk("f_err", d, 32'(f_err[d]), 32'(x_f_err[d]));
      chk("f_rdata", d, 32'(f_rdata[d]), 32'(x_f_rdata[d]));
      chk("e_ready", d, 32'(e_ready[d]), 32'(x_e_ready[d]));
      chk("e_err", d, 32'(e_err[d]), 32'(x_e_err[d]));
      chk("e_rdata", d, 32'(e_rdata[d]), 32'(x_e_rdata[d]));
      if (x_mem_req[d]) chk("mem_addr", d, 32'(mem_addr[d]), 32'(x_addr[d]));
      if (x_mem_we[d])  chk("mem_wdata", d, 32'(mem_wdata[d]), 32'(x_wdata[d]));

      if (mem_req[d]) begin
        cur_addr[d] = mem_addr[d]; cur_we[d] = mem_we[d]; cur_wdata[d] = mem_wdata[d];
      end
      if (f_ready[d] || e_ready[d]) begin
        rec.is_e  = e_ready[d];
        rec.err   = f_err[d] | e_err[d];
        rec.rdata = e_ready[d] ? e_rdata[d] : f_rdata[d];
        rec.busy  = busy_n[d];
        rec.addr  = cur_addr[d];
        rec.we    = cur_we[d];
        rec.wdata = cur_wdata[d];
        if (d == 0) log0.push_back(rec); else log1.push_back(rec);
      end

      if (f_ready[d]) begin f_req[d] = 1'b0; f_gap[d] = f_again[d]; end
      else if (f_gap[d]) begin f_gap[d] = 1'b0; f_req[d] = 1'b1; end
      if (e_ready[d]) begin e_req[d] = 1'b0; e_gap[d] = e_again[d]; end
      else if (e_gap[d]) begin e_gap[d] = 1'b0; e_req[d] = 1'b1; end

      if (mem_req[d]) begin
        busy_n[d]++;
        mem_ready[d] = ready_always[d] || (lat[d] != 0 && busy_n[d] == lat[d]);
      end else begin
        busy_n[d]    = 0;
        mem_ready[d] = ready_always[d];
      end
      mem_rdata[d] = rdata_val[d];
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int log_size(input int d);
    return (d == 0) ? log0.size() : log1.size();
  endfunction

  task automatic expect_txn(input string nm, input int d, input int i, input bit is_e, input bit err,
                            input logic [7:0] rdata, input int busy, input logic [7:0] addr,
                            input bit we, input logic [7:0] wdata);
    txn_t t;
    int   n;
    n = log_size(d);
    if (i >= n) begin
      checks++;
      errors++;
      $display("FAIL %s dut%0d: transaction %0d missing, only %0d logged", nm, d, i, n);
    end else begin
      t = (d == 0) ? log0[i] : log1[i];
      chk({nm, "_port"}, d, 32'(t.is_e), 32'(is_e));
      chk({nm, "_err"}, d, 32'(t.err), 32'(err));
      chk({nm, "_rdata"}, d, 32'(t.rdata), 32'(rdata));
      chk({nm, "_busy"}, d, 32'(t.busy), 32'(busy));
      chk({nm, "_addr"}, d, 32'(t.addr), 32'(addr));
      chk({nm, "_we"}, d, 32'(t.we), 32'(we));
      if (we) chk({nm, "_wdata"}, d, 32'(t.wdata), 32'(wdata));
    end
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      f_req[d] = 0; e_req[d] = 0; e_we[d] = 0; mem_ready[d] = 0;
      f_addr[d] = 0; e_addr[d] = 0; e_wdata[d] = 0; mem_rdata[d] = 0;
      lat[d] = 1; busy_n[d] = 0; ready_always[d] = 0; rdata_val[d] = 0;
      f_again[d] = 0; e_again[d] = 0; f_gap[d] = 0; e_gap[d] = 0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_mem_req", d, 32'(mem_req[d]), 32'd0);
      chk("rst_grant", d, 32'(grant[d]), 32'd0);
      chk("rst_f_ready", d, 32'(f_ready[d]), 32'd0);
      chk("rst_e_ready", d, 32'(e_ready[d]), 32'd0);
      chk("rst_f_rdata", d, 32'(f_rdata[d]), 32'd0);
      chk("rst_mem_addr", d, 32'(mem_addr[d]), 32'd0);
    end
    cycles(1);
    rst = 1'b0;
    cycles(2);

    // Single fetch, one BUSY cycle.
    clear_logs();
    for (int d = 0; d < 2; d++) begin
      rdata_val[d] = 8'hA5; lat[d] = 1; f_addr[d] = 8'h10; f_req[d] = 1'b1;
    end
    cycles(8);
    for (int d = 0; d < 2; d++) begin
      chk("fetch_count", d, 32'(log_size(d)), 32'd1);
      expect_txn("fetch", d, 0, 1'b0, 1'b0, 8'hA5, 1, 8'h10, 1'b0, 8'h00);
    end

    // Execute write, three BUSY cycles.
    clear_logs();
    for (int d = 0; d < 2; d++) begin
      lat[d] = 3; rdata_val[d] = 8'hC3;
      e_we[d] = 1'b1; e_addr[d] = 8'h80; e_wdata[d] = 8'h3C; e_req[d] = 1'b1;
    end
    cycles(10);
    for (int d = 0; d < 2; d++) begin
      expect_txn("ewrite", d, 0, 1'b1, 1'b0, 8'hC3, 3, 8'h80, 1'b1, 8'h3C);
      e_we[d] = 1'b0;
    end

    // Continuous contention: alternation for dut 0, E always for dut 1.
    clear_logs();
    for (int d = 0; d < 2; d++) begin
      lat[d] = 2; rdata_val[d] = 8'h11; f_addr[d] = 8'h01; e_addr[d] = 8'h02;
      f_again[d] = 1'b1; e_again[d] = 1'b1; f_req[d] = 1'b1; e_req[d] = 1'b1;
    end
    cycles(24);
    for (int d = 0; d < 2; d++) begin
      f_again[d] = 1'b0; e_again[d] = 1'b0;
    end
    cycles(16);
    for (int i = 0; i < 4; i++) begin
      expect_txn("rr_order", 0, i, (i % 2) == 1, 1'b0, 8'h11, 2, ((i % 2) == 1) ? 8'h02 : 8'h01, 1'b0, 8'h00);
      expect_txn("fp_order", 1, i, 1'b1, 1'b0, 8'h11, 2, 8'h02, 1'b0, 8'h00);
    end
    expect_txn("fp_last", 1, (log1.size() > 0) ? log1.size() - 1 : 0, 1'b0, 1'b0, 8'h11, 2, 8'h01, 1'b0, 8'h00);

    // Timeout on E, then a pending F is served.
    clear_logs();
    for (int d = 0; d < 2; d++) begin
      lat[d] = 0; rdata_val[d] = 8'h77; e_addr[d] = 8'h44; e_req[d] = 1'b1;
    end
    cycles(3);
    for (int d = 0; d < 2; d++) begin
      f_addr[d] = 8'h21; lat[d] = 2; f_req[d] = 1'b1;
    end
    cycles(30);
    for (int d = 0; d < 2; d++) begin
      expect_txn("timeout", d, 0, 1'b1, 1'b1, 8'h00, TMO, 8'h44, 1'b0, 8'h00);
      expect_txn("after_to", d, 1, 1'b0, 1'b0, 8'h77, 2, 8'h21, 1'b0, 8'h00);
    end

    // mem_ready in the timeout cycle completes normally.
    clear_logs();
    for (int d = 0; d < 2; d++) begin
      lat[d] = TMO; rdata_val[d] = 8'h5A; e_req[d] = 1'b1;
    end
    cycles(24);
    for (int d = 0; d < 2; d++)
      expect_txn("coincide", d, 0, 1'b1, 1'b0, 8'h5A, TMO, 8'h44, 1'b0, 8'h00);

    // Level mem_ready: exactly one transaction, ready outside BUSY ignored.
    clear_logs();
    for (int d = 0; d < 2; d++) begin
      ready_always[d] = 1'b1; rdata_val[d] = 8'h96; f_addr[d] = 8'h33; f_req[d] = 1'b1;
    end
    cycles(8);
    for (int d = 0; d < 2; d++) begin
      ready_always[d] = 1'b0;
      chk("level_count", d, 32'(log_size(d)), 32'd1);
      expect_txn("level", d, 0, 1'b0, 1'b0, 8'h96, 1, 8'h33, 1'b0, 8'h00);
    end
    cycles(2);

    // Asynchronous reset in BUSY, held f_req re-granted afterwards.
    clear_logs();
    for (int d = 0; d < 2; d++) begin
      lat[d] = 0; f_addr[d] = 8'h55; f_req[d] = 1'b1;
    end
    cycles(4);
    for (int d = 0; d < 2; d++) begin
      chk("pre_rst_mem_req", d, 32'(mem_req[d]), 32'd1);
      chk("pre_rst_grant", d, 32'(grant[d]), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_mem_req", d, 32'(mem_req[d]), 32'd0);
      chk("arst_mem_we", d, 32'(mem_we[d]), 32'd0);
      chk("arst_grant", d, 32'(grant[d]), 32'd0);
      chk("arst_f_ready", d, 32'(f_ready[d]), 32'd0);
      chk("arst_e_ready", d, 32'(e_ready[d]), 32'd0);
      chk("arst_f_err", d, 32'(f_err[d]), 32'd0);
      lat[d] = 1;
    end
    @(negedge clk);
    rst = 1'b0;
    cycles(8);
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_count", d, 32'(log_size(d)), 32'd1);
      expect_txn("post_rst", d, 0, 1'b0, 1'b0, 8'h96, 1, 8'h55, 1'b0, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
